// File: rtl/encoder_pkg.sv
// Shared defaults, FSM state type and a one-hot helper for the 8-to-3 scheduled encoder.
package encoder_pkg;

   localparam int N_REQ_DEFAULT  = 8;
   localparam int CODE_W_DEFAULT = 3;
   localparam int ONEHOT_W       = 64;

   typedef enum logic {IDLE, PRESENT} state_t;

   // Wide enough for any sensible N_REQ; callers truncate to their own width.
   function automatic logic [ONEHOT_W-1:0] onehot(input logic [31:0] code);
      return ONEHOT_W'(1) << code;
   endfunction

endpackage

// File: rtl/encoder8to3_sched_prio_sel.sv
// Combinational request selector: fixed highest-index priority, or rotating
// priority starting at rr_ptr when ROUND_ROBIN_EN is defined.
module prio_sel #(
   parameter int N = 8,
   parameter int W = 3
) (
   input  logic [N-1:0] vec,
   input  logic [W-1:0] rr_ptr,
   output logic [W-1:0] code,
   output logic         any
);

`ifdef ROUND_ROBIN_EN
   logic [W-1:0] idx;

   // Scan from the farthest candidate back to rr_ptr so the nearest hit wins.
   always_comb begin
      code = '0;
      idx  = '0;
      any  = |vec;
      for (int k = N - 1; k >= 0; k--) begin
         idx = W'((int'(rr_ptr) + k) % N);
         if (vec[idx]) code = idx;
      end
   end
`else
   logic unused_rr_ptr;
   assign unused_rr_ptr = ^rr_ptr;

   always_comb begin
      code = '0;
      any  = |vec;
      for (int i = 0; i < N; i++) begin
         if (vec[i]) code = W'(i);
      end
   end
`endif

endmodule

// File: rtl/encoder8to3_sched.sv
// Sequential 8-to-3 encoder: sticky pending requests served one code per handshake.
// Define ROUND_ROBIN_EN for rotating priority; default is fixed highest-index priority.
module encoder8to3_sched
   import encoder_pkg::*;
#(
   parameter int N_REQ  = N_REQ_DEFAULT,
   parameter int CODE_W = CODE_W_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [N_REQ-1:0]  req,
   output logic              out_valid,
   output logic [CODE_W-1:0] out_code,
   input  logic              out_ready,
   output logic [N_REQ-1:0]  pending,
   output logic              coalesced
);

   generate
      if (CODE_W != $clog2(N_REQ)) begin : g_bad_code_w
         $error("CODE_W must equal $clog2(N_REQ)");
      end
   endgenerate

   state_t            state;
   logic              hs;
   logic [N_REQ-1:0]  cap;
   logic [N_REQ-1:0]  clr_mask;
   logic [N_REQ-1:0]  pending_nxt;
   logic [CODE_W-1:0] sel_ptr;
   logic [CODE_W-1:0] sel_code;
   logic              sel_any;

   always_comb begin
      hs          = out_valid & out_ready;
      cap         = req & {N_REQ{en}};
      clr_mask    = hs ? N_REQ'(onehot(32'(out_code))) : '0;
      pending_nxt = (pending & ~clr_mask) | cap;
   end

`ifdef ROUND_ROBIN_EN
   logic [CODE_W-1:0] rr_ptr;
   logic [CODE_W-1:0] code_inc;

   assign code_inc = (out_code == CODE_W'(N_REQ - 1)) ? '0 : out_code + 1'b1;
   // The search for the next code already uses the pointer this handshake produces.
   assign sel_ptr  = hs ? code_inc : rr_ptr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr <= '0;
      end else if (hs) begin
         rr_ptr <= code_inc;
      end
   end
`else
   assign sel_ptr = '0;
`endif

   prio_sel #(
      .N (N_REQ),
      .W (CODE_W)
   ) u_prio_sel (
      .vec    (pending_nxt),
      .rr_ptr (sel_ptr),
      .code   (sel_code),
      .any    (sel_any)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending   <= '0;
         out_valid <= 1'b0;
         out_code  <= '0;
         coalesced <= 1'b0;
         state     <= IDLE;
      end else begin
         pending   <= pending_nxt;
         coalesced <= |(cap & pending & ~clr_mask);
         case (state)
            IDLE: begin
               if (|pending) begin
                  out_code  <= sel_code;
                  out_valid <= 1'b1;
                  state     <= PRESENT;
               end
            end
            PRESENT: begin
               // Held code is never pre-empted; only a handshake advances it.
               if (hs) begin
                  if (sel_any) begin
                     out_code <= sel_code;
                  end else begin
                     out_valid <= 1'b0;
                     state     <= IDLE;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_encoder8to3_sched.sv
// Self-checking bench for encoder8to3_sched: directed scenarios plus random traffic
// against a queue-level reference model.
module tb_encoder8to3_sched;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [7:0] req;
   logic       out_valid;
   logic [2:0] out_code;
   logic       out_ready;
   logic [7:0] pending;
   logic       coalesced;

   int checks   = 0;
   int failures = 0;

   // Reference model state
   logic [7:0] m_pend;
   bit         m_valid;
   int         m_code;
   int         m_rr;
   bit         m_coal;

   always #5 clk = ~clk;

   encoder8to3_sched dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .req       (req),
      .out_valid (out_valid),
      .out_code  (out_code),
      .out_ready (out_ready),
      .pending   (pending),
      .coalesced (coalesced)
   );

   // Which pending request is served next, from the priority rule alone.
   function automatic int pick(input logic [7:0] v, input int start);
`ifdef ROUND_ROBIN_EN
      for (int k = 0; k < 8; k++) begin
         if (v[(start + k) % 8]) return (start + k) % 8;
      end
`else
      for (int i = 7; i >= 0; i--) begin
         if (v[i]) return i;
      end
`endif
      return 0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pend  = 8'h00;
      m_valid = 1'b0;
      m_code  = 0;
      m_rr    = 0;
      m_coal  = 1'b0;
   endtask

   // One clock: predict, advance, then compare every output against the model.
   task automatic cycle();
      logic [7:0] served;
      logic [7:0] cap;
      logic [7:0] nxt;
      bit         hs;
      int         start;
      hs     = m_valid && out_ready;
      served = hs ? 8'(1 << m_code) : 8'h00;
      cap    = en ? req : 8'h00;
      nxt    = (m_pend & ~served) | cap;
      start  = hs ? (m_code + 1) % 8 : m_rr;
      if (hs && !rst) $display("xfer code=%0d", m_code);
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else begin
         m_coal = |(cap & m_pend & ~served);
         if (!m_valid) begin
            if (m_pend != 8'h00) begin
               m_valid = 1'b1;
               m_code  = pick(nxt, start);
            end
         end else if (hs) begin
            if (nxt != 8'h00) m_code = pick(nxt, start);
            else m_valid = 1'b0;
         end
         if (hs) m_rr = start;
         m_pend = nxt;
      end
      #1;
      chk("valid", 32'(out_valid), 32'(m_valid));
      if (m_valid) chk("code", 32'(out_code), 32'(m_code));
      chk("pending", 32'(pending), 32'(m_pend));
      chk("coalesced", 32'(coalesced), 32'(m_coal));
   endtask

   initial begin
      int seq3 [4];
      int seq6 [4];
      int hold_code;
      int next_code;
`ifdef ROUND_ROBIN_EN
      seq3 = '{5, 7, 0, 2};
      seq6 = '{0, 7, 0, 7};
      hold_code = 1;
      next_code = 2;
`else
      seq3 = '{7, 5, 2, 0};
      seq6 = '{7, 7, 7, 7};
      hold_code = 2;
      next_code = 1;
`endif
      rst = 1'b1; en = 1'b1; req = 8'h00; out_ready = 1'b1;
      model_reset();
      #2;
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_code", 32'(out_code), 0);
      chk("rst_pending", 32'(pending), 0);
      chk("rst_coal", 32'(coalesced), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      cycle();

      // Single request: valid two edges after it is seen, cleared by the handshake
      req = 8'h10; cycle();
      req = 8'h00; cycle();
      chk("single_valid", 32'(out_valid), 1);
      chk("single_code", 32'(out_code), 4);
      cycle();
      chk("single_pend_cleared", 32'(pending), 0);
      chk("single_idle", 32'(out_valid), 0);

      // Multi-hot burst drains back to back
      req = 8'b1010_0101; cycle();
      req = 8'h00; cycle();
      for (int i = 0; i < 4; i++) begin
         chk("burst_code", 32'(out_code), 32'(seq3[i]));
         chk("burst_valid", 32'(out_valid), 1);
         cycle();
      end
      chk("burst_done", 32'(out_valid), 0);

      // Backpressure holds the code; a repeat request coalesces
      out_ready = 1'b0;
      req = 8'h06; cycle();
      req = 8'h00; cycle();
      for (int i = 0; i < 5; i++) begin
         req = (i == 2) ? 8'h04 : 8'h00;
         cycle();
         chk("hold_valid", 32'(out_valid), 1);
         chk("hold_code", 32'(out_code), 32'(hold_code));
         if (i == 2) chk("coal_pulse", 32'(coalesced), 1);
         if (i == 3) chk("coal_drop", 32'(coalesced), 0);
      end
      req = 8'h00;
      out_ready = 1'b1; cycle();
      chk("release_code", 32'(out_code), 32'(next_code));
      cycle();
      chk("release_done", 32'(out_valid), 0);

      // Capture disabled: requests ignored
      en = 1'b0; req = 8'hFF;
      repeat (3) cycle();
      chk("en0_pending", 32'(pending), 0);
      chk("en0_valid", 32'(out_valid), 0);

      // Set wins over clear on the served bit
      en = 1'b1; req = 8'h08; cycle();
      req = 8'h00; cycle();
      chk("setwin_first", 32'(out_code), 3);
      req = 8'h08; cycle();
      chk("setwin_valid", 32'(out_valid), 1);
      chk("setwin_code", 32'(out_code), 3);
      chk("setwin_pend3", 32'(pending[3]), 1);
      req = 8'h00; cycle();
      chk("setwin_done", 32'(out_valid), 0);

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         en        = ($urandom_range(0, 3) != 0);
         req       = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
         out_ready = ($urandom_range(0, 3) != 0);
         cycle();
      end
      en = 1'b1; req = 8'h00; out_ready = 1'b1;
      repeat (10) cycle();

      // Reset mid-stream clears everything at once
      out_ready = 1'b0; req = 8'hFF; cycle();
      req = 8'h00; cycle();
      chk("pre_rst_pending", 32'(pending), 32'hFF);
      chk("pre_rst_valid", 32'(out_valid), 1);
      #2 rst = 1'b1;
      #1;
      model_reset();
      chk("async_rst_valid", 32'(out_valid), 0);
      chk("async_rst_pending", 32'(pending), 0);
      chk("async_rst_code", 32'(out_code), 0);
      chk("async_rst_coal", 32'(coalesced), 0);
      cycle();
      rst = 1'b0; out_ready = 1'b1;
      repeat (4) cycle();
      chk("post_rst_quiet", 32'(out_valid), 0);

      // Two requests held asserted
      req = 8'h81; cycle();
      cycle();
      for (int i = 0; i < 4; i++) begin
         chk("held_code", 32'(out_code), 32'(seq6[i]));
         cycle();
      end
      req = 8'h00;
      repeat (4) cycle();
      chk("final_idle", 32'(out_valid), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
